// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : {pc, instr} record buffered toward decode
//   INSTR_NOP     : canonical RISC-V nop (addi x0, x0, 0)
//   FETCH_STEP    : byte increment between sequential word fetches
package riscv_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] FETCH_STEP = 32'd4;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t records between the OBI response path and decode.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   push, push_data   : write one entry (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   flush             : empty the FIFO; wins over push and pop
//   head              : current head entry
//   count, empty      : occupancy
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        do_push = push && (count != CNT_W'(DEPTH));
        do_pop  = pop && (count != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch stage: OBI instruction-bus master with credit-limited sequential
// prefetch, in-order response buffering and branch redirect with stale-response discard.
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   branch_i, branch_addr_i          : redirect pulse and target (low two bits ignored)
//   instr_req_o, instr_addr_o        : OBI request / word address
//   instr_gnt_i                      : OBI grant
//   instr_rvalid_i, instr_rdata_i    : OBI response
//   fetch_valid_o, fetch_pc_o,
//   fetch_instr_o, fetch_ready_i     : {pc, instr} handshake toward decode
//   busy_o                           : at least one granted request awaits its response
module riscv_fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    input  logic        fetch_ready_i,
    output logic        busy_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Registered state
    logic             req_q;
    logic [31:0]      addr_q;
    logic [31:0]      fetch_addr_q;
    logic [31:0]      resp_pc_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] discard_q;
    logic             stale_q;
    logic             busy_q;

    // Next-state values
    logic             req_n;
    logic [31:0]      addr_n;
    logic [31:0]      fetch_addr_n;
    logic [31:0]      resp_pc_n;
    logic [OUT_W-1:0] out_n;
    logic [OUT_W-1:0] discard_n;
    logic             stale_n;
    logic [CNT_W-1:0] cnt_n;

    logic             gnt_fire;
    logic             rv_drop;
    logic             push;
    logic             pop;
    logic             credit_ok;
    logic [31:0]      target;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (branch_i),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Next-state: grant/response accounting, discard tracking, redirect and credit check
    always_comb begin
        gnt_fire         = req_q && instr_gnt_i;
        rv_drop          = instr_rvalid_i && (discard_q != '0);
        push             = instr_rvalid_i && !rv_drop && !branch_i;
        pop              = fetch_valid_o && fetch_ready_i && !branch_i;
        target           = branch_addr_i & ~32'd3;
        push_entry.pc    = resp_pc_q;
        push_entry.instr = instr_rdata_i;

        out_n = out_q + OUT_W'(gnt_fire) - OUT_W'(instr_rvalid_i);
        cnt_n = branch_i ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));

        // A request left pending across a branch is stale: its response is dropped once granted
        if (branch_i) begin
            discard_n = out_n;
            stale_n   = req_q && !instr_gnt_i;
        end else begin
            discard_n = discard_q - OUT_W'(rv_drop) + OUT_W'(gnt_fire && stale_q);
            stale_n   = stale_q && !gnt_fire;
        end

        fetch_addr_n = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_n = target;
        end else if (gnt_fire && !stale_q) begin
            fetch_addr_n = fetch_addr_q + FETCH_STEP;
        end

        resp_pc_n = resp_pc_q;
        if (branch_i) begin
            resp_pc_n = target;
        end else if (push) begin
            resp_pc_n = resp_pc_q + FETCH_STEP;
        end

        // Credit is judged on next-cycle occupancy so every granted response has a FIFO slot
        credit_ok = (32'(out_n) < MAX_OUTSTANDING)
                 && ((32'(out_n) + 32'(cnt_n)) < FIFO_DEPTH);

        req_n  = credit_ok;
        addr_n = credit_ok ? fetch_addr_n : addr_q;
        if (req_q && !instr_gnt_i) begin
            req_n  = 1'b1;
            addr_n = addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q        <= 1'b0;
            addr_q       <= BOOT_ADDR;
            fetch_addr_q <= BOOT_ADDR;
            resp_pc_q    <= BOOT_ADDR;
            out_q        <= '0;
            discard_q    <= '0;
            stale_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            req_q        <= req_n;
            addr_q       <= addr_n;
            fetch_addr_q <= fetch_addr_n;
            resp_pc_q    <= resp_pc_n;
            out_q        <= out_n;
            discard_q    <= discard_n;
            stale_q      <= stale_n;
            busy_q       <= (out_n != '0);
        end
    end

    assign instr_req_o   = req_q;
    assign instr_addr_o  = addr_q;
    assign busy_o        = busy_q;
    assign fetch_valid_o = !fifo_empty;
    assign fetch_pc_o    = head.pc;
    assign fetch_instr_o = head.instr;

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
- Instruction fetch unit that masters the OBI instruction interface of the instruction memory.
- Issues sequential word fetches and tracks requests that have been granted but not yet answered.
- Buffers responses in a small FIFO and presents {pc, instr} to decode with a valid/ready handshake.
- On a branch it redirects fetch, flushes buffered entries and discards stale in-flight responses.

Parameters:
- FIFO_DEPTH, 4, number of {pc, instr} entries buffered toward decode (power of 2, >= 2).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered OBI requests.
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk, in, 1, single clock; all logic on its rising edge.
- reset_n, in, 1, asynchronous, active-low reset.
- branch_i, in, 1, redirect request, single-cycle pulse.
- branch_addr_i, in, 32, redirect target; bits [1:0] are ignored and forced to 0.
- instr_req_o, out, 1, OBI request.
- instr_addr_o, out, 32, OBI word address.
- instr_gnt_i, in, 1, OBI grant.
- instr_rvalid_i, in, 1, OBI response valid.
- instr_rdata_i, in, 32, OBI read data.
- fetch_valid_o, out, 1, FIFO head is valid.
- fetch_instr_o, out, 32, FIFO head instruction.
- fetch_pc_o, out, 32, FIFO head PC.
- fetch_ready_i, in, 1, decode accepts the head this cycle.
- busy_o, out, 1, at least one OBI request is outstanding.

Behaviour:
- Reset (asynchronous, active-low, takes effect mid-operation as well):
  - outputs: instr_req_o=0, instr_addr_o=BOOT_ADDR, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0, busy_o=0.
  - internal state: fetch_addr=BOOT_ADDR, resp_pc=BOOT_ADDR, outstanding=0, discard_cnt=0, FIFO empty.
  - All in-flight state is dropped.
- Credit rule:
  - A new request may be raised only when outstanding < MAX_OUTSTANDING and outstanding + fifo_count < FIFO_DEPTH.
  - This guarantees every accepted response has a FIFO slot; FIFO overflow is impossible.
- OBI request rules:
  - Once instr_req_o=1 without instr_gnt_i, instr_req_o and instr_addr_o hold stable until granted, even across a branch.
  - Grant may arrive in any cycle, including the cycle the request is raised.
  - On req&&gnt: fetch_addr += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding += 1.
  - The request is dropped in the next cycle if credit is exhausted.
- Responses:
  - Responses arrive in order, at most one per cycle; each rvalid decrements outstanding.
  - If discard_cnt > 0, the response is dropped and discard_cnt -= 1.
  - Otherwise {resp_pc, instr_rdata_i} is pushed and resp_pc += 4.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
- Decode output:
  - fetch_valid_o = FIFO not empty; outputs are driven from the FIFO head.
  - A pop occurs on fetch_valid_o && fetch_ready_i.
  - Push and pop in the same cycle are allowed.
  - There is no bypass: minimum latency from rvalid to fetch_valid_o is 1 cycle.
- Branch (branch_i=1); a branch has priority over everything else:
  - The FIFO is flushed; fetch_valid_o=0 in the next cycle, and any same-cycle pop is void.
  - A same-cycle rvalid is dropped.
  - discard_cnt <= outstanding after this cycle's grant/rvalid updates.
  - A pending ungranted request counts toward discard_cnt once granted.
  - fetch_addr <= branch_addr_i & ~3 and resp_pc <= the same value.
  - The first request to the target is raised after any pending ungranted request is granted.
  - A second branch before the discards drain accumulates: discard_cnt covers all outstanding requests.
- busy_o = (outstanding != 0), registered.

Decomposition:
- Shared package riscv_fetch_pkg:
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Constant INSTR_NOP = 32'h0000_0013.
  - Constant FETCH_STEP = 4.
- One sub-module: riscv_fetch_fifo.
  - Synchronous FIFO of fetch_entry_t with parameter DEPTH.
  - Inputs: push, pop, flush; outputs: count and empty.
  - flush has priority over push/pop.
- Request, credit and discard logic stay in the top.

Test Plan:
- Reset release, BOOT_ADDR=0, mem words 0..3 = 0x00100093, 0x00200113, 0x00300193, 0x00400213, fetch_ready_i=1 -> fetch_valid_o delivers pc 0,4,8,12 with matching instr, in order, no duplicates.
- fetch_ready_i=0 for 20 cycles -> exactly 4 entries buffered, instr_req_o=0 once credits are exhausted, no further grants; release ready -> pc 0..12 then 16 onward, contiguous.
- With 2 requests outstanding, branch_i pulse, branch_addr_i=0x40 -> both responses dropped; next fetch_valid_o has pc=0x40 and instr=mem[0x40].
- Branch while instr_req_o=1 and gnt=0 at addr 0x8 -> instr_addr_o stays 0x8 until granted, that response is dropped, and the next request addr is 0x40.
- branch_i, instr_rvalid_i and a pop in the same cycle -> fetch_valid_o=0 next cycle; the first delivered pc equals the branch target.
- branch_addr_i=0xFFFF_FFFE -> delivered pc sequence 0xFFFF_FFFC then 0x0000_0000.
